// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI responder.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SHIFT
    } spi_slv_state_e;

    localparam int unsigned SPI_DATA_W = 8;

    // Replicated to the frame width when the tx holding buffer is empty at LOAD.
    localparam logic SPI_TX_FILL = 1'b0;

endpackage

// File: rtl/spi_sync_edge.sv
// N-flop synchronizer with rising/falling edge pulses taken against one extra flop.
module spi_sync_edge #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_in};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign sync_out = sync_q[STAGES-1];
    assign rise     = sync_q[STAGES-1] & ~prev_q;
    assign fall     = ~sync_q[STAGES-1] & prev_q;

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI mode-0 responder oversampled on clk; one-deep tx holding buffer.
// Define SPI_SLAVE_LSB_FIRST_EN for LSB-first framing (default MSB first).
module spi_slave_ctrl
    import spi_pkg::*;
#(
    parameter int unsigned DATA_W      = SPI_DATA_W,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              SCL,
    input  logic              CS_n,
    input  logic              MOSI,
    output logic              MISO,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              frame_err
);

    localparam int unsigned CNT_W   = $clog2(DATA_W) + 1;
    localparam int unsigned BLANK_W = $clog2(SYNC_STAGES + 2);
    localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]   CNT_FULL   = CNT_W'(DATA_W);
    localparam logic [BLANK_W-1:0] BLANK_INIT = BLANK_W'(SYNC_STAGES + 1);
`ifdef SPI_SLAVE_LSB_FIRST_EN
    localparam int unsigned TX_BIT = 0;
`else
    localparam int unsigned TX_BIT = DATA_W - 1;
`endif

    logic unused_scl_lvl, unused_mosi_rise, unused_mosi_fall;
    logic scl_rise, scl_fall, cs_sync, cs_rise, cs_fall, mosi_sync;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_scl (
        .clk(clk), .resetn(resetn), .async_in(SCL),
        .sync_out(unused_scl_lvl), .rise(scl_rise), .fall(scl_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
        .clk(clk), .resetn(resetn), .async_in(CS_n),
        .sync_out(cs_sync), .rise(cs_rise), .fall(cs_fall)
    );
    spi_sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .resetn(resetn), .async_in(MOSI),
        .sync_out(mosi_sync), .rise(unused_mosi_rise), .fall(unused_mosi_fall)
    );

    spi_slv_state_e    state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0] rx_shift_q, rx_shift_d, tx_shift_q, tx_shift_d;
    logic [DATA_W-1:0] hold_q, hold_d, rx_data_q, rx_data_d;
    logic              hold_full_q, hold_full_d, rx_valid_q, rx_valid_d;
    logic              frame_err_q, frame_err_d, miso_q, miso_d;
    logic [BLANK_W-1:0] blank_q;

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_shift_d  = rx_shift_q;
        tx_shift_d  = tx_shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = 1'b0;
        frame_err_d = 1'b0;
        miso_d      = miso_q;

        if (tx_load && !hold_full_q) begin
            hold_d      = tx_data;
            hold_full_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                miso_d    = 1'b0;
                bit_cnt_d = '0;
                // A CS_n low seen across reset is a sync-chain artefact, not a new frame.
                if (cs_fall && blank_q == '0) state_d = LOAD;
            end
            LOAD: begin
                bit_cnt_d = '0;
                if (hold_full_q) begin
                    tx_shift_d  = hold_q;
                    hold_full_d = 1'b0;
                end else begin
                    tx_shift_d = {DATA_W{SPI_TX_FILL}};
                end
                miso_d  = tx_shift_d[TX_BIT];
                state_d = SHIFT;
            end
            SHIFT: begin
                if (scl_rise && !cs_sync) begin
`ifdef SPI_SLAVE_LSB_FIRST_EN
                    rx_shift_d = {mosi_sync, rx_shift_q[DATA_W-1:1]};
`else
                    rx_shift_d = {rx_shift_q[DATA_W-2:0], mosi_sync};
`endif
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == CNT_LAST) begin
                        rx_data_d  = rx_shift_d;
                        rx_valid_d = 1'b1;
                    end
                end else if (scl_fall && !cs_sync && bit_cnt_q != '0) begin
                    // The fall that trails the last rise belongs to the next byte, whose
                    // first bit LOAD already placed on MISO, so bit_cnt==0 falls are skipped.
`ifdef SPI_SLAVE_LSB_FIRST_EN
                    tx_shift_d = {1'b0, tx_shift_q[DATA_W-1:1]};
`else
                    tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
`endif
                    miso_d = tx_shift_d[TX_BIT];
                end
                if (bit_cnt_q == CNT_FULL) state_d = LOAD;
            end
            default: state_d = IDLE;
        endcase

        if (cs_rise) begin
            frame_err_d = (state_q == SHIFT) && (bit_cnt_q != '0) && (bit_cnt_q != CNT_FULL);
            state_d     = IDLE;
            bit_cnt_d   = '0;
            rx_shift_d  = '0;
            miso_d      = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            rx_shift_q  <= '0;
            tx_shift_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rx_data_q   <= '0;
            rx_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            miso_q      <= 1'b0;
            blank_q     <= BLANK_INIT;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_shift_q  <= rx_shift_d;
            tx_shift_q  <= tx_shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            frame_err_q <= frame_err_d;
            miso_q      <= miso_d;
            if (blank_q != '0) blank_q <= blank_q - 1'b1;
        end
    end

    assign MISO      = miso_q;
    assign tx_ready  = ~hold_full_q;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_spi_slave_ctrl.sv
// Directed bench for spi_slave_ctrl: bus-level mode-0 master with hand-computed expectations.
module tb_spi_slave_ctrl;

    localparam int HALF = 8;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic       SCL = 1'b0;
    logic       CS_n = 1'b1;
    logic       MOSI = 1'b0;
    logic       MISO;
    logic [7:0] tx_data = 8'h00;
    logic       tx_load = 1'b0;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rv_cnt = 0;
    int rv_wide = 0;
    int rv_stamp = 0;
    int rv_prev_stamp = 0;
    int fe_cnt = 0;
    logic rv_d = 1'b0;

    spi_slave_ctrl #(.DATA_W(8), .SYNC_STAGES(2)) dut (
        .clk(clk), .resetn(resetn), .SCL(SCL), .CS_n(CS_n), .MOSI(MOSI), .MISO(MISO),
        .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        rv_d <= rx_valid;
        if (rx_valid) begin
            rv_cnt        <= rv_cnt + 1;
            rv_prev_stamp <= rv_stamp;
            rv_stamp      <= cyc;
        end
        if (rx_valid && rv_d) rv_wide <= rv_wide + 1;
        if (frame_err) fe_cnt <= fe_cnt + 1;
    end

    // Expected byte as seen on the wire when the bench shifts MSB first.
    function automatic logic [7:0] ord(input logic [7:0] b);
`ifdef SPI_SLAVE_LSB_FIRST_EN
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
`else
        return b;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic load_tx(input logic [7:0] d);
        tx_data = d;
        tx_load = 1'b1;
        cycles(1);
        tx_load = 1'b0;
    endtask

    task automatic cs_low();
        CS_n = 1'b0;
        cycles(10);
    endtask

    task automatic cs_high();
        cycles(HALF);
        CS_n = 1'b1;
        cycles(10);
    endtask

    // Sends the top nbits of mo MSB first; MISO is sampled just before each SCL rise.
    task automatic xfer_bits(input logic [7:0] mo, input int nbits, output logic [7:0] mi);
        mi = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            MOSI = mo[7-i];
            cycles(HALF);
            mi = {mi[6:0], MISO};
            SCL = 1'b1;
            cycles(HALF);
            SCL = 1'b0;
        end
    endtask

    logic [7:0] mi;
    int rv_base, fe_base;

    initial begin
        // Reset state
        cycles(2);
        check("rst_miso", 32'(MISO), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_data", 32'(rx_data), 32'h00);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        resetn = 1'b1;
        cycles(3);

        // 1: single byte 0xA5 in, 0x3C out
        load_tx(8'h3C);
        check("t1_tx_ready_low", 32'(tx_ready), 32'd0);
        cs_low();
        check("t1_tx_ready_back", 32'(tx_ready), 32'd1);
        xfer_bits(8'hA5, 8, mi);
        check("t1_miso", 32'(mi), 32'(ord(8'h3C)));
        cs_high();
        check("t1_rx_data", 32'(rx_data), 32'(ord(8'hA5)));
        check("t1_rv_cnt", 32'(rv_cnt), 32'd1);
        check("t1_fe_cnt", 32'(fe_cnt), 32'd0);

        // 2: back-to-back bytes in one frame
        load_tx(8'hF0);
        cs_low();
        check("t2_tx_ready", 32'(tx_ready), 32'd1);
        load_tx(8'h0F);
        check("t2_tx_ready_low", 32'(tx_ready), 32'd0);
        xfer_bits(8'h01, 8, mi);
        check("t2_miso0", 32'(mi), 32'(ord(8'hF0)));
        check("t2_rx0", 32'(rx_data), 32'(ord(8'h01)));
        xfer_bits(8'h80, 8, mi);
        check("t2_miso1", 32'(mi), 32'(ord(8'h0F)));
        cs_high();
        check("t2_rx1", 32'(rx_data), 32'(ord(8'h80)));
        check("t2_rv_cnt", 32'(rv_cnt), 32'd3);
        check("t2_rv_gap", 32'(rv_stamp - rv_prev_stamp), 32'd128);

        // 3: underrun sends zeros
        check("t3_tx_ready", 32'(tx_ready), 32'd1);
        cs_low();
        xfer_bits(8'hFF, 8, mi);
        check("t3_miso", 32'(mi), 32'h00);
        cs_high();
        check("t3_rx_data", 32'(rx_data), 32'hFF);
        check("t3_rv_cnt", 32'(rv_cnt), 32'd4);

        // 4: CS_n rise after 5 bits of 0xC3
        cs_low();
        xfer_bits(8'hC3, 5, mi);
        cs_high();
        check("t4_fe_cnt", 32'(fe_cnt), 32'd1);
        check("t4_rv_cnt", 32'(rv_cnt), 32'd4);
        check("t4_rx_kept", 32'(rx_data), 32'hFF);
        cs_low();
        xfer_bits(8'h5A, 8, mi);
        cs_high();
        check("t4_rx_next", 32'(rx_data), 32'(ord(8'h5A)));
        check("t4_rv_next", 32'(rv_cnt), 32'd5);

        // 5: reset after the 4th bit aborts the frame
        rv_base = rv_cnt;
        fe_base = fe_cnt;
        cs_low();
        load_tx(8'h11);
        check("t5_tx_ready_low", 32'(tx_ready), 32'd0);
        xfer_bits(8'h99, 4, mi);
        resetn = 1'b0;
        cycles(1);
        resetn = 1'b1;
        check("t5_rst_miso", 32'(MISO), 32'd0);
        check("t5_rst_tx_ready", 32'(tx_ready), 32'd1);
        check("t5_rst_rx_data", 32'(rx_data), 32'h00);
        check("t5_rst_rx_valid", 32'(rx_valid), 32'd0);
        xfer_bits(8'h90, 4, mi);
        check("t5_miso_idle", 32'(mi), 32'h00);
        cs_high();
        check("t5_no_rv", 32'(rv_cnt), 32'(rv_base));
        check("t5_no_fe", 32'(fe_cnt), 32'(fe_base));
        check("t5_rx_cleared", 32'(rx_data), 32'h00);
        cs_low();
        xfer_bits(8'h99, 8, mi);
        cs_high();
        check("t5_rx_99", 32'(rx_data), 32'(ord(8'h99)));
        check("t5_rv_99", 32'(rv_cnt), 32'(rv_base + 1));

`ifdef SPI_SLAVE_LSB_FIRST_EN
        // 6: LSB-first framing
        load_tx(8'h02);
        cs_low();
        xfer_bits(8'h80, 8, mi);
        cs_high();
        check("t6_rx_data", 32'(rx_data), 32'h01);
        check("t6_miso", 32'(mi), 32'h40);
`endif

        check("rv_pulse_width", 32'(rv_wide), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_ctrl.md
Name: spi_slave_ctrl

Overview:
SPI responder (slave) for the SPI environment. Runs entirely on the system clock and oversamples the master-driven SCL, CS_n and MOSI. Supports SPI mode 0 only (CPOL=0, CPHA=0), 8-bit frames, MSB first, and back-to-back bytes within one CS_n assertion. Presents received bytes on rx_data with a valid pulse, and accepts bytes to return on MISO through a one-deep tx holding buffer.

Parameters:
DATA_W, 8, frame width in bits.
SYNC_STAGES, 2, flop stages per synchronizer on SCL, CS_n and MOSI (minimum 2).

Ports:
clk  input  1  system clock; all logic runs on its rising edge.
resetn  input  1  synchronous reset, active low.
SCL  input  1  SPI serial clock from the master; asynchronous to clk.
CS_n  input  1  chip select from the master, active low; asynchronous.
MOSI  input  1  master-out serial data; asynchronous.
MISO  output  1  slave-out serial data.
tx_data  input  DATA_W  byte to return to the master.
tx_load  input  1  writes tx_data into the holding buffer when tx_ready=1.
tx_ready  output  1  holding buffer is empty.
rx_data  output  DATA_W  last complete received byte.
rx_valid  output  1  one-cycle pulse when rx_data updates.
frame_err  output  1  one-cycle pulse when CS_n deasserts mid-byte.

Behaviour:
- Reset: one clk rising edge with resetn=0 clears everything. After reset: MISO=0, tx_ready=1, rx_data=0, rx_valid=0, frame_err=0, all shift and bit counters 0, state IDLE, synchronizer flops set to SCL=0, CS_n=1, MOSI=0.
- Synchronization: each async input passes through SYNC_STAGES flops. Edges are detected by comparing the last sync stage with one further flop. Constraint on the master: each SCL half-period is at least SYNC_STAGES+2 clk cycles.
- States:
  - IDLE: waiting for CS_n to fall.
  - LOAD: transfer the next byte into the tx shift register.
  - SHIFT: clock bits in and out.
- Transitions:
  - IDLE->LOAD on a synced CS_n falling edge.
  - LOAD->SHIFT after exactly 1 cycle.
  - SHIFT->LOAD when the bit count reaches DATA_W and CS_n is still low.
  - Any state->IDLE on a synced CS_n rising edge.
- LOAD:
  - If the holding buffer is full, move it into tx_shift and set tx_ready=1 on the next cycle.
  - Otherwise load all-zeros into tx_shift (underrun).
  - MISO = tx_shift[DATA_W-1] from the cycle after LOAD.
- SHIFT:
  - On a synced SCL rising edge: shift synced MOSI into rx_shift LSB-side and increment bit_cnt.
  - On a synced SCL falling edge: shift tx_shift left and drive the new MSB onto MISO.
  - On the 8th rising edge: rx_data <= assembled byte and rx_valid=1 for exactly the next cycle. Latency is 1 clk after edge detection.
- Holding buffer:
  - tx_load with tx_ready=1 captures tx_data and drops tx_ready on the next cycle.
  - tx_load with tx_ready=0 is ignored; contents are unchanged.
  - A tx_load in the same cycle as a LOAD transfer is not accepted; tx_ready is still 0 in that cycle.
- CS_n rising edge with bit_cnt not 0 and not DATA_W:
  - frame_err pulses for 1 cycle.
  - The partial byte is discarded; rx_valid does not fire.
  - The holding buffer is retained.
- CS_n rising edge on a byte boundary: no error.
- While in IDLE, MISO=0 (no tri-state inside the block).
- SCL edges while CS_n is high are ignored.
- bit_cnt width is clog2(DATA_W)+1 and clears on entry to LOAD and to IDLE.
- resetn=0 during a transfer aborts it immediately: no rx_valid, no frame_err, reset values as above.

Optional Feature:
SPI_SLAVE_LSB_FIRST_EN.
- Defined: bits are transmitted and received LSB first. tx_shift shifts right and MISO drives tx_shift[0]; rx bits enter at the MSB side.
- Undefined: MSB first, as described above.

Decomposition:
- Package spi_pkg holds:
  - state enum typedef spi_slv_state_e {IDLE, LOAD, SHIFT};
  - localparam SPI_DATA_W=8;
  - the underrun fill value SPI_TX_FILL='0.
- Sub-module spi_sync_edge, instantiated three times: a parameterized N-flop synchronizer with rise/fall pulse outputs.

Test Plan:
1. Reset, then the master sends 0xA5 with tx buffer loaded with 0x3C -> rx_data=0xA5 with a single rx_valid pulse; the master samples 0x3C on MISO; tx_ready returns to 1 in the cycle after LOAD.
2. Two bytes in one CS_n frame (0x01, 0x80); tx loaded with 0xF0, then 0x0F after tx_ready -> two rx_valid pulses at least 8 SCL edges apart; MISO returns 0xF0 then 0x0F.
3. No tx_load before the frame, master sends 0xFF -> MISO is all zeros; rx_data=0xFF.
4. CS_n deasserted after 5 SCL rising edges of 0xC3 -> frame_err pulses once; no rx_valid; rx_data keeps its previous value; the next full byte 0x5A is received correctly.
5. resetn=0 for 1 cycle after the 4th bit of a transfer -> all outputs take reset values, the remaining SCL edges in the frame are ignored until the next CS_n fall, and a following 0x99 transfer is received correctly.
6. With SPI_SLAVE_LSB_FIRST_EN defined, master sends bit sequence 1,0,0,0,0,0,0,0 -> rx_data=0x01; tx 0x02 appears on MISO as 0,1,0,0,0,0,0,0.
